telemetry_rx: RTL and testbench

Receive-side telemetry frame parser. It consumes the byte stream from a `UART_rcv` instance on the monitoring side of the link and locks onto the 8-byte frames the e-bike telemetry transmitter sends roughly every 2^20 clocks. It recovers the 12-bit battery voltage, current and torque samples, presents them atomically with a one-cycle valid strobe, and reports framing and timeout errors.

---
 rtl/telemetry_rx.sv | 126 ++++++++++++
 tb/tb_telemetry_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/telemetry_rx.sv
// Receive-side telemetry frame parser: locks onto AA 55 framed 8-byte records from UART_rcv,
// publishes battery/current/torque atomically, flags framing errors and mid-frame byte timeouts.
module telemetry_rx #(
  parameter int TMO_CYC = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rdy,
  output logic        clr_rdy,
  output logic [11:0] batt_v,
  output logic [11:0] curr,
  output logic [11:0] torque,
  output logic        frame_vld,
  output logic        frm_err,
  output logic        tmo_err,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {SYNC1, SYNC2, BH, BL, CH, CL, TH, TL} state_t;

  localparam logic [19:0] TMO_LAST = 20'(TMO_CYC - 1);

  state_t      r_state;
  logic [19:0] r_tmo_cnt;
  logic [11:0] r_batt_sh;
  logic [11:0] r_curr_sh;
  logic [11:0] r_torq_sh;

  logic w_acc;
  logic w_hi_state;
  logic w_frm_hit;
  logic w_tmo_hit;

  // rdy stays high one cycle past clr_rdy, so masking with clr_rdy consumes each byte once
  assign w_acc      = rdy & ~clr_rdy;
  assign w_hi_state = (r_state == BH) || (r_state == CH) || (r_state == TH);
  assign w_frm_hit  = w_acc && w_hi_state && (rx_data[7:4] != 4'h0);
  // an accept in the same cycle as the timeout wins
  assign w_tmo_hit  = !w_acc && (r_state != SYNC1) && (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= SYNC1;
      r_tmo_cnt <= '0;
      r_batt_sh <= '0;
      r_curr_sh <= '0;
      r_torq_sh <= '0;
      clr_rdy   <= 1'b0;
      batt_v    <= '0;
      curr      <= '0;
      torque    <= '0;
      frame_vld <= 1'b0;
      frm_err   <= 1'b0;
      tmo_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      clr_rdy   <= w_acc;
      frame_vld <= 1'b0;
      frm_err   <= w_frm_hit;
      tmo_err   <= w_tmo_hit;

      if ((w_frm_hit || w_tmo_hit) && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end

      if (w_acc) begin
        r_tmo_cnt <= '0;
        case (r_state)
          SYNC1: if (rx_data == 8'hAA) r_state <= SYNC2;
          SYNC2: begin
            if (rx_data == 8'h55)      r_state <= BH;
            else if (rx_data != 8'hAA) r_state <= SYNC1;
          end
          BH: begin
            if (w_frm_hit) r_state <= SYNC1;
            else begin
              r_batt_sh[11:8] <= rx_data[3:0];
              r_state         <= BL;
            end
          end
          BL: begin
            r_batt_sh[7:0] <= rx_data;
            r_state        <= CH;
          end
          CH: begin
            if (w_frm_hit) r_state <= SYNC1;
            else begin
              r_curr_sh[11:8] <= rx_data[3:0];
              r_state         <= CL;
            end
          end
          CL: begin
            r_curr_sh[7:0] <= rx_data;
            r_state        <= TH;
          end
          TH: begin
            if (w_frm_hit) r_state <= SYNC1;
            else begin
              r_torq_sh[11:8] <= rx_data[3:0];
              r_state         <= TL;
            end
          end
          TL: begin
            // torque low goes straight to the output; its shadow is not needed
            r_torq_sh[7:0] <= rx_data;
            batt_v         <= r_batt_sh;
            curr           <= r_curr_sh;
            torque         <= {r_torq_sh[11:8], rx_data};
            frame_vld      <= 1'b1;
            r_state        <= SYNC1;
          end
          default: r_state <= SYNC1;
        endcase
      end else if (w_tmo_hit) begin
        r_state   <= SYNC1;
        r_tmo_cnt <= '0;
      end else if (r_state == SYNC1) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 20'd1;
      end
    end
  end

endmodule

// File: tb/tb_telemetry_rx.sv
// Directed bench for telemetry_rx: a UART_rcv-like driver feeds byte sequences, results checked against hand values.
module tb_telemetry_rx;

  localparam int TMO = 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rdy = 1'b0;
  logic        clr_rdy;
  logic [11:0] batt_v, curr, torque;
  logic        frame_vld, frm_err, tmo_err;
  logic [7:0]  err_cnt;

  telemetry_rx #(.TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rdy(rdy), .clr_rdy(clr_rdy),
    .batt_v(batt_v), .curr(curr), .torque(torque), .frame_vld(frame_vld),
    .frm_err(frm_err), .tmo_err(tmo_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_clr = 0, n_vld = 0, n_frm = 0, n_tmo = 0;
  int n_chk = 0, n_bad = 0;
  int last_clr_cyc = -1;
  logic s_vld, s_frm;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (clr_rdy)   n_clr++;
    if (frame_vld) n_vld++;
    if (frm_err)   n_frm++;
    if (tmo_err)   n_tmo++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; rdy held through the clr_rdy cycle, dropped the cycle after, then gap idle cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b;
    rdy     = 1'b1;
    @(negedge clk);
    if (clr_rdy) last_clr_cyc = cyc;
    s_vld = frame_vld;
    s_frm = frm_err;
    @(negedge clk);
    rdy = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_seq(input logic [7:0] seq[$], input int gap);
    foreach (seq[i]) send_byte(seq[i], gap);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int clr0, vld0, tmo0, frm0, tmo_cyc;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_clr_rdy", clr_rdy, 0);
    check("rst_batt", batt_v, 0);
    check("rst_curr", curr, 0);
    check("rst_torque", torque, 0);
    check("rst_flags", {frame_vld, frm_err, tmo_err}, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // clean frame with ~100-cycle byte spacing
    clr0 = n_clr; vld0 = n_vld;
    send_seq('{8'hAA, 8'h55, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h0F, 8'hFF}, 98);
    check("clean_vld_pulse", s_vld, 1);
    check("clean_batt", batt_v, 12'hABC);
    check("clean_curr", curr, 12'h123);
    check("clean_torque", torque, 12'hFFF);
    check("clean_clr_pulses", n_clr - clr0, 8);
    check("clean_vld_count", n_vld - vld0, 1);
    check("clean_err_cnt", err_cnt, 0);

    // garbage, then doubled sync byte
    vld0 = n_vld;
    send_seq('{8'h13, 8'hAA, 8'hAA, 8'h55, 8'h00, 8'h11, 8'h00, 8'h22, 8'h00, 8'h33}, 1);
    check("dsync_batt", batt_v, 12'h011);
    check("dsync_curr", curr, 12'h022);
    check("dsync_torque", torque, 12'h033);
    check("dsync_vld_count", n_vld - vld0, 1);
    check("dsync_err_cnt", err_cnt, 0);

    // bad current high byte; outputs hold, then a good frame decodes
    vld0 = n_vld;
    send_seq('{8'hAA, 8'h55, 8'h0A, 8'hBC}, 1);
    send_byte(8'h31, 1);
    check("bad_frm_pulse", s_frm, 1);
    send_seq('{8'h23, 8'h0F, 8'hFF}, 1);
    check("bad_hold_batt", batt_v, 12'h011);
    check("bad_hold_torque", torque, 12'h033);
    check("bad_no_vld", n_vld - vld0, 0);
    check("bad_err_cnt", err_cnt, 1);
    send_seq('{8'hAA, 8'h55, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h0F, 8'hFF}, 1);
    check("after_bad_batt", batt_v, 12'hABC);
    check("after_bad_curr", curr, 12'h123);
    check("after_bad_torque", torque, 12'hFFF);

    // mid-frame silence: tmo_err is TMO cycles after the clr_rdy of the last byte
    tmo0 = n_tmo;
    send_seq('{8'hAA, 8'h55}, 1);
    send_byte(8'h0A, 0);
    tmo_cyc = -1;
    for (int i = 0; i < 3 * TMO; i++) begin
      if (tmo_err) begin
        tmo_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    check("tmo_delay", tmo_cyc - last_clr_cyc, TMO);
    repeat (3) @(negedge clk);
    check("tmo_single_pulse", n_tmo - tmo0, 1);
    check("tmo_err_cnt", err_cnt, 2);
    send_seq('{8'hAA, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 1);
    check("after_tmo_batt", batt_v, 12'h102);
    check("after_tmo_curr", curr, 12'h304);
    check("after_tmo_torque", torque, 12'h506);

    // next accept lands exactly on the timeout cycle
    tmo0 = n_tmo; vld0 = n_vld;
    send_seq('{8'hAA, 8'h55}, 1);
    send_byte(8'h05, TMO - 2);
    send_seq('{8'h67, 8'h08, 8'h9A, 8'h0C, 8'hDE}, 1);
    repeat (2) @(negedge clk);
    check("edge_no_tmo", n_tmo - tmo0, 0);
    check("edge_vld_count", n_vld - vld0, 1);
    check("edge_batt", batt_v, 12'h567);
    check("edge_curr", curr, 12'h89A);
    check("edge_torque", torque, 12'hCDE);
    check("edge_err_cnt", err_cnt, 2);

    // reset mid-frame discards the partial frame
    send_seq('{8'hAA, 8'h55, 8'h0A, 8'hBC}, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_batt", batt_v, 0);
    check("midrst_curr", curr, 0);
    check("midrst_torque", torque, 0);
    check("midrst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vld0 = n_vld;
    send_seq('{8'h01, 8'h23, 8'h0F, 8'hFF}, 1);
    check("midrst_no_vld", n_vld - vld0, 0);
    check("midrst_keep_zero", {batt_v, curr, torque}, 0);

    // error counter saturation
    frm0 = n_frm;
    for (int i = 0; i < 300; i++) begin
      send_seq('{8'hAA, 8'h55, 8'h31}, 1);
      if (i == 253) check("sat_err_cnt_254", err_cnt, 254);
    end
    check("sat_frm_pulses", n_frm - frm0, 300);
    check("sat_err_cnt", err_cnt, 255);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
